fpga_spi_cmd_rx: RTL and testbench
==================================

Name: fpga_spi_cmd_rx

Overview:
- Clock-domain-safe replacement for the ARM→FPGA SPI configuration receiver that feeds the major-mode muxes and the HF sub-modules.
- Oversamples spck/mosi/ncs on the FPGA clock and assembles 16-bit MSB-first command words.
- Decodes each word and publishes conf_word and divisor as registered outputs.
- Holds a new conf_word pending until an apply strobe, so mode changes never glitch the carrier.

Parameters:
- WORD_BITS, 16, bits per SPI frame; frame valid only if exactly this many spck rising edges occur.
- SYNC_STAGES, 2, synchroniser depth on spck, mosi and ncs (minimum 2).
- CONF_RESET, 8'hE0, conf_word value after reset (major mode 111, everything off).
- DIV_RESET, 8'd95, divisor value after reset.

Ports:
- ck_1356meg  in  1  system clock; all state on its rising edge.
- rst  in  1  synchronous, active-high reset.
- spck  in  1  SPI clock from ARM, asynchronous; max freq ck_1356meg/4.
- mosi  in  1  SPI data, sampled on spck rising edge.
- ncs  in  1  SPI chip select, active low.
- apply_stb  in  1  one-cycle safe point (e.g. carrier/frame boundary) at which a pending conf_word is committed.
- conf_word  out  8  active configuration; major_mode = conf_word[7:5].
- divisor  out  8  LF clock divisor.
- conf_pending  out  1  new conf_word received, not yet applied.
- cmd_stb  out  1  one-cycle pulse: a valid frame was decoded (any command).
- frame_err  out  1  one-cycle pulse: frame discarded (wrong bit count).
- cmd_unknown  out  1  one-cycle pulse: valid frame with an unrecognised command.

Behaviour:
- Reset (synchronous, active-high, rst): conf_word=CONF_RESET, divisor=DIV_RESET, conf_pending=0, all pulses 0, bit counter 0, state IDLE, synchroniser flops loaded with idle levels (ncs=1, spck=0, mosi=0).
- Synchronisation: each input passes through SYNC_STAGES flops. Edge detection uses the last synchronised stage and a one-flop delayed copy.
- Event definitions:
  - sck_rise: synchronised spck 0→1.
  - cs_fall / cs_rise: synchronised ncs 1→0 / 0→1.
- FSM states: IDLE, SHIFT, DECODE.
  - IDLE: on cs_fall → SHIFT; clear bit counter and shift register.
  - SHIFT: on each sck_rise, shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_sync} and increment the counter. The counter saturates at WORD_BITS+1 (overflow marker). On cs_rise → DECODE.
  - DECODE (one cycle, then → IDLE):
    - Counter != WORD_BITS: frame_err=1, no register change.
    - Otherwise cmd_stb=1, then decode on word[15:12]:
      - 4'b0001 SET_CONFREG: pending_conf <= word[7:0], conf_pending <= 1.
      - 4'b0010 SET_DIVISOR: divisor <= word[7:0], effective the cycle after DECODE.
      - any other value: cmd_unknown=1, no register change.
- Simultaneous sck_rise and cs_rise in the same cycle: the sck_rise shift is performed first, then → DECODE. This edge counts toward the bit count.
- cs_fall while in SHIFT cannot occur without an intervening cs_rise. If the synchronised ncs is seen low in IDLE without a fall (e.g. after reset), stay in IDLE until a clean cs_fall; the partial frame is ignored and does not raise frame_err.
- Apply:
  - apply_stb=1 and conf_pending=1: conf_word <= pending_conf, conf_pending <= 0, visible the next cycle.
  - apply_stb=1 and conf_pending=0: no effect.
- Simultaneous events:
  - DECODE writes CONFREG in the same cycle as apply_stb: the old pending value is applied and the new value stays pending (conf_pending remains 1).
  - A second CONFREG before apply: overwrites pending_conf (last write wins).
- Latency: cs_rise at the pin → cmd_stb after SYNC_STAGES+2 cycles.
- Mid-frame reset: frame discarded, no pulses, registers return to reset values.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package fpga_cmd_pkg holds:
  - Command codes CMD_SET_CONFREG=4'b0001 and CMD_SET_DIVISOR=4'b0010.
  - Major-mode encodings, including MODE_OFF=3'b111 and MODE_HF_NFC=3'b101.
  - FSM state enumeration.
- One sub-module: sync_edge (SYNC_STAGES-deep synchroniser with rise/fall outputs), instantiated for spck and ncs. mosi uses a plain synchroniser of the same depth so its data stays aligned with the spck edge it belongs to.

Test Plan:
- Reset → conf_word=8'hE0, divisor=95, conf_pending=0, no pulses.
- SPI frame 16'h10A1, then apply_stb two cycles later → cmd_stb pulse, conf_pending=1, conf_word stays 8'hE0 until apply; after apply conf_word=8'hA1, conf_pending=0.
- Frame 16'h2020 → divisor=32 one cycle after cmd_stb; conf_word unchanged; conf_pending stays 0.
- 15-bit frame and 17-bit frame → frame_err pulses once each; conf_word, divisor and conf_pending unchanged.
- Frame 16'h70FF → cmd_stb and cmd_unknown pulse; no register change.
- Frames 16'h1011 then 16'h1022, with apply_stb coincident with the second DECODE → conf_word=8'h11, conf_pending=1; next apply_stb → conf_word=8'h22. Also assert rst mid-frame → no pulses, reset values restored.

Source files
------------

// File: rtl/fpga_cmd_pkg.sv
// Shared definitions for the ARM->FPGA SPI configuration path: command
// codes carried in the top nibble of each word, major-mode encodings
// found in conf_word[7:5], and the receiver state enumeration.
package fpga_cmd_pkg;

    // Command codes (word[15:12])
    localparam logic [3:0] CMD_SET_CONFREG = 4'b0001;
    localparam logic [3:0] CMD_SET_DIVISOR = 4'b0010;

    // Major-mode encodings (conf_word[7:5])
    localparam logic [2:0] MODE_HF_READER_TX = 3'b000;
    localparam logic [2:0] MODE_HF_READER_RX = 3'b001;
    localparam logic [2:0] MODE_HF_SIMULATOR = 3'b010;
    localparam logic [2:0] MODE_HF_ISO14443A = 3'b011;
    localparam logic [2:0] MODE_LF_READER    = 3'b100;
    localparam logic [2:0] MODE_HF_NFC       = 3'b101;
    localparam logic [2:0] MODE_LF_EDGE      = 3'b110;
    localparam logic [2:0] MODE_OFF          = 3'b111;

    // Receiver states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE
    } rx_state_t;

endpackage

// File: rtl/fpga_spi_cmd_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with rise/fall
// detection on the synchronised level. Edges are suppressed until the
// pipeline and the delayed copy hold only real samples, so the idle
// value loaded at reset never produces a phantom edge.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;
    logic [SYNC_STAGES:0]   fill;
    logic                   level;

    // Shift the raw input through the synchroniser, keep a one-cycle
    // delayed copy of the last stage, and track when the chain is primed
    always_ff @(posedge clk) begin
        if (rst) begin
            stages <= {SYNC_STAGES{IDLE_LEVEL}};
            prev   <= IDLE_LEVEL;
            fill   <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
            prev   <= stages[SYNC_STAGES-1];
            fill   <= {fill[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = stages[SYNC_STAGES-1];
    assign rise  = fill[SYNC_STAGES] & level & ~prev;
    assign fall  = fill[SYNC_STAGES] & ~level & prev;

endmodule

// File: rtl/fpga_spi_cmd_rx.sv
// ARM->FPGA SPI command receiver. Oversamples spck/mosi/ncs on the
// 13.56 MHz clock, assembles MSB-first words, decodes them and publishes
// conf_word/divisor as registered outputs. A received conf_word is held
// pending until apply_stb so the carrier never sees a mid-cycle change.
module fpga_spi_cmd_rx
    import fpga_cmd_pkg::*;
#(
    parameter int         WORD_BITS   = 16,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CONF_RESET  = 8'hE0,
    parameter logic [7:0] DIV_RESET   = 8'd95
) (
    input  logic       ck_1356meg,
    input  logic       rst,
    input  logic       spck,
    input  logic       mosi,
    input  logic       ncs,
    input  logic       apply_stb,
    output logic [7:0] conf_word,
    output logic [7:0] divisor,
    output logic       conf_pending,
    output logic       cmd_stb,
    output logic       frame_err,
    output logic       cmd_unknown
);

    localparam int             CNT_W    = $clog2(WORD_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_BITS + 1);

    logic                   sck_rise;
    logic                   cs_fall;
    logic                   cs_rise;
    logic [SYNC_STAGES-1:0] mosi_stages;
    logic                   mosi_sync;

    rx_state_t              state;
    logic [WORD_BITS-1:0]   shift_reg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [7:0]             pending_conf;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_LEVEL  (1'b0)
    ) u_sync_spck (
        .clk  (ck_1356meg),
        .rst  (rst),
        .din  (spck),
        .rise (sck_rise),
        .fall ()
    );

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .IDLE_LEVEL  (1'b1)
    ) u_sync_ncs (
        .clk  (ck_1356meg),
        .rst  (rst),
        .din  (ncs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Plain synchroniser for mosi, same depth as spck so each data bit
    // lines up with the spck edge that qualifies it
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            mosi_stages <= '0;
        end else begin
            mosi_stages <= {mosi_stages[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_sync = mosi_stages[SYNC_STAGES-1];

    // Frame FSM, decoder and apply logic; the DECODE write to the pending
    // register is placed after the apply so a coincident apply commits the
    // old pending value while the new one stays pending
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            state        <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            pending_conf <= CONF_RESET;
            conf_word    <= CONF_RESET;
            divisor      <= DIV_RESET;
            conf_pending <= 1'b0;
            cmd_stb      <= 1'b0;
            frame_err    <= 1'b0;
            cmd_unknown  <= 1'b0;
        end else begin
            cmd_stb     <= 1'b0;
            frame_err   <= 1'b0;
            cmd_unknown <= 1'b0;

            if (apply_stb && conf_pending) begin
                conf_word    <= pending_conf;
                conf_pending <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_sync};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    if (cs_rise) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= ST_IDLE;
                    if (bit_cnt != CNT_FULL) begin
                        frame_err <= 1'b1;
                    end else begin
                        cmd_stb <= 1'b1;
                        case (shift_reg[WORD_BITS-1 -: 4])
                            CMD_SET_CONFREG: begin
                                pending_conf <= shift_reg[7:0];
                                conf_pending <= 1'b1;
                            end
                            CMD_SET_DIVISOR: begin
                                divisor <= shift_reg[7:0];
                            end
                            default: begin
                                cmd_unknown <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_spi_cmd_rx.sv
// Self-checking bench for fpga_spi_cmd_rx: directed SPI frames from a
// vector table plus hand-written sequences for latency, apply timing,
// coincident apply/decode and mid-frame reset.
module tb_fpga_spi_cmd_rx;

    logic       ck_1356meg = 1'b0;
    logic       rst;
    logic       spck;
    logic       mosi;
    logic       ncs;
    logic       apply_stb;
    logic [7:0] conf_word;
    logic [7:0] divisor;
    logic       conf_pending;
    logic       cmd_stb;
    logic       frame_err;
    logic       cmd_unknown;

    int tests_run    = 0;
    int tests_failed = 0;

    int         n_cmd;
    int         n_err;
    int         n_unk;
    int         first_cmd;
    logic [7:0] conf_at_cmd;
    logic       pend_at_cmd;
    logic [7:0] div_after_cmd;

    typedef struct {
        logic [16:0] frame;
        int          nbits;
        logic        apply;
        int          exp_cmd;
        int          exp_err;
        int          exp_unk;
        logic [7:0]  exp_conf;
        logic [7:0]  exp_div;
        logic        exp_pend;
    } vec_t;

    vec_t vecs[10];

    fpga_spi_cmd_rx dut (
        .ck_1356meg   (ck_1356meg),
        .rst          (rst),
        .spck         (spck),
        .mosi         (mosi),
        .ncs          (ncs),
        .apply_stb    (apply_stb),
        .conf_word    (conf_word),
        .divisor      (divisor),
        .conf_pending (conf_pending),
        .cmd_stb      (cmd_stb),
        .frame_err    (frame_err),
        .cmd_unknown  (cmd_unknown)
    );

    // 13.56 MHz stand-in clock
    always #5 ck_1356meg = ~ck_1356meg;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge ck_1356meg);
    endtask

    task automatic sendBits(input logic [16:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = data[i];
            waitCycles(2);
            spck = 1'b1;
            waitCycles(3);
            spck = 1'b0;
        end
    endtask

    // Full frame: select, clock out nbits MSB-first, deselect on a negedge
    task automatic applyStimulus(input logic [16:0] data, input int nbits);
        ncs = 1'b0;
        waitCycles(4);
        sendBits(data, nbits);
        waitCycles(2);
        ncs = 1'b1;
    endtask

    // Observe a fixed window after deselect, counting pulses; apply_stb is
    // driven high for the edge that ends cycle apply_at (0 = never)
    task automatic watchPulses(input int cycles, input int apply_at);
        n_cmd = 0;
        n_err = 0;
        n_unk = 0;
        first_cmd = -1;
        conf_at_cmd = 8'h00;
        pend_at_cmd = 1'b0;
        div_after_cmd = 8'h00;
        for (int k = 1; k <= cycles; k++) begin
            apply_stb = (k == apply_at);
            @(negedge ck_1356meg);
            apply_stb = 1'b0;
            if (cmd_stb) begin
                n_cmd++;
                if (first_cmd < 0) begin
                    first_cmd   = k;
                    conf_at_cmd = conf_word;
                    pend_at_cmd = conf_pending;
                end
            end
            if (first_cmd > 0 && k == first_cmd + 1) div_after_cmd = divisor;
            if (frame_err) n_err++;
            if (cmd_unknown) n_unk++;
        end
    endtask

    task automatic doApply();
        apply_stb = 1'b1;
        @(negedge ck_1356meg);
        apply_stb = 1'b0;
    endtask

    // Main test sequence
    initial begin
        vecs[0] = '{17'h02040, 16, 1'b0, 1, 0, 0, 8'hA1, 8'h40, 1'b0};
        vecs[1] = '{17'h010BB, 15, 1'b0, 0, 1, 0, 8'hA1, 8'h40, 1'b0};
        vecs[2] = '{17'h110CC, 17, 1'b0, 0, 1, 0, 8'hA1, 8'h40, 1'b0};
        vecs[3] = '{17'h070FF, 16, 1'b0, 1, 0, 1, 8'hA1, 8'h40, 1'b0};
        vecs[4] = '{17'h01033, 16, 1'b1, 1, 0, 0, 8'h33, 8'h40, 1'b0};
        vecs[5] = '{17'h02001, 16, 1'b1, 1, 0, 0, 8'h33, 8'h01, 1'b0};
        vecs[6] = '{17'h01044, 16, 1'b0, 1, 0, 0, 8'h33, 8'h01, 1'b1};
        vecs[7] = '{17'h0F044, 16, 1'b0, 1, 0, 1, 8'h33, 8'h01, 1'b1};
        vecs[8] = '{17'h01055, 16, 1'b0, 1, 0, 0, 8'h33, 8'h01, 1'b1};
        vecs[9] = '{17'h00000, 16, 1'b1, 1, 0, 1, 8'h55, 8'h01, 1'b0};

        rst = 1'b1;
        spck = 1'b0;
        mosi = 1'b0;
        ncs = 1'b1;
        apply_stb = 1'b0;
        waitCycles(3);

        checkOutput("reset conf_word", conf_word, 8'hE0);
        checkOutput("reset divisor", divisor, 8'd95);
        checkOutput("reset conf_pending", conf_pending, 1'b0);
        checkOutput("reset cmd_stb", cmd_stb, 1'b0);
        checkOutput("reset frame_err", frame_err, 1'b0);
        checkOutput("reset cmd_unknown", cmd_unknown, 1'b0);
        rst = 1'b0;
        waitCycles(5);

        // CONFREG 0xA1, latency check, apply two cycles after cmd_stb
        applyStimulus(17'h010A1, 16);
        watchPulses(12, 6);
        checkOutput("a1 latency", first_cmd, 4);
        checkOutput("a1 cmd count", n_cmd, 1);
        checkOutput("a1 conf before apply", conf_at_cmd, 8'hE0);
        checkOutput("a1 pending at cmd", pend_at_cmd, 1'b1);
        checkOutput("a1 conf after apply", conf_word, 8'hA1);
        checkOutput("a1 pending after apply", conf_pending, 1'b0);

        // SET_DIVISOR 32
        applyStimulus(17'h02020, 16);
        watchPulses(12, 0);
        checkOutput("div32 cmd count", n_cmd, 1);
        checkOutput("div32 divisor after cmd", div_after_cmd, 8'd32);
        checkOutput("div32 conf", conf_word, 8'hA1);
        checkOutput("div32 pending", conf_pending, 1'b0);

        // Table-driven frames
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].frame, vecs[i].nbits);
            watchPulses(12, 0);
            if (vecs[i].apply) doApply();
            checkOutput($sformatf("vec%0d cmd_stb", i), n_cmd, vecs[i].exp_cmd);
            checkOutput($sformatf("vec%0d frame_err", i), n_err, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d cmd_unknown", i), n_unk, vecs[i].exp_unk);
            checkOutput($sformatf("vec%0d conf_word", i), conf_word, vecs[i].exp_conf);
            checkOutput($sformatf("vec%0d divisor", i), divisor, vecs[i].exp_div);
            checkOutput($sformatf("vec%0d conf_pending", i), conf_pending, vecs[i].exp_pend);
        end

        // Coincident apply with the second CONFREG decode
        applyStimulus(17'h01011, 16);
        watchPulses(12, 0);
        checkOutput("c11 pending", conf_pending, 1'b1);
        checkOutput("c11 conf", conf_word, 8'h55);
        applyStimulus(17'h01022, 16);
        watchPulses(12, 4);
        checkOutput("c22 latency", first_cmd, 4);
        checkOutput("c22 conf at decode", conf_at_cmd, 8'h11);
        checkOutput("c22 pending at decode", pend_at_cmd, 1'b1);
        checkOutput("c22 conf after", conf_word, 8'h11);
        checkOutput("c22 pending after", conf_pending, 1'b1);
        doApply();
        checkOutput("c22 conf applied", conf_word, 8'h22);
        checkOutput("c22 pending cleared", conf_pending, 1'b0);

        // Reset in the middle of a frame; ncs stays low across reset
        ncs = 1'b0;
        waitCycles(4);
        sendBits(17'h000FF, 8);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        checkOutput("midrst conf", conf_word, 8'hE0);
        checkOutput("midrst divisor", divisor, 8'd95);
        checkOutput("midrst pending", conf_pending, 1'b0);
        sendBits(17'h000AA, 8);
        waitCycles(2);
        ncs = 1'b1;
        watchPulses(12, 0);
        checkOutput("midrst cmd count", n_cmd, 0);
        checkOutput("midrst err count", n_err, 0);
        checkOutput("midrst unk count", n_unk, 0);
        checkOutput("midrst divisor after", divisor, 8'd95);

        // Receiver still works after the reset
        applyStimulus(17'h02010, 16);
        watchPulses(12, 0);
        checkOutput("post cmd count", n_cmd, 1);
        checkOutput("post divisor", divisor, 8'h10);
        checkOutput("post conf", conf_word, 8'hE0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
